// File: rtl/conv_pkg.sv
// Shared constants, FSM state encoding and window/tap address tables
// for the convolution MAC sequencer.
package conv_pkg;

    localparam int PIX_W   = 4;
    localparam int IMG_DIM = 4;
    localparam int K_DIM   = 3;
    localparam int ACC_W   = 11;
    localparam int N_PIX   = IMG_DIM * IMG_DIM;
    localparam int N_TAP   = K_DIM * K_DIM;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_OUT  = 2'b10,
        ST_FIN  = 2'b11
    } state_t;

    // Window origin (r0,c0) per index, flattened to r0*IMG_DIM + c0.
    function automatic logic [3:0] win_origin(input logic [1:0] win);
        case (win)
            2'd0:    win_origin = 4'd0;
            2'd1:    win_origin = 4'd1;
            2'd2:    win_origin = 4'd4;
            2'd3:    win_origin = 4'd5;
            default: win_origin = 4'd0;
        endcase
    endfunction

    // Tap (row*3+col) to flattened image offset row*IMG_DIM + col.
    function automatic logic [3:0] tap_offset(input logic [3:0] tap);
        case (tap)
            4'd0:    tap_offset = 4'd0;
            4'd1:    tap_offset = 4'd1;
            4'd2:    tap_offset = 4'd2;
            4'd3:    tap_offset = 4'd4;
            4'd4:    tap_offset = 4'd5;
            4'd5:    tap_offset = 4'd6;
            4'd6:    tap_offset = 4'd8;
            4'd7:    tap_offset = 4'd9;
            4'd8:    tap_offset = 4'd10;
            default: tap_offset = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Window/tap position counter; derives the image read address for the
// current MAC step and flags the final tap of a window.
module conv_tap_counter
    import conv_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clear,
    input  logic       advance,
    input  logic       next_win,
    output logic [1:0] win,
    output logic [3:0] tap,
    output logic [3:0] pix_addr,
    output logic       last_tap
);

    logic [1:0] win_r;
    logic [3:0] tap_r;

    // Position registers: clear wins over window step, which wins over tap step.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            win_r <= 2'd0;
            tap_r <= 4'd0;
        end else if (clear) begin
            win_r <= 2'd0;
            tap_r <= 4'd0;
        end else if (next_win) begin
            win_r <= win_r + 2'd1;
            tap_r <= 4'd0;
        end else if (advance) begin
            tap_r <= tap_r + 4'd1;
        end
    end

    assign win      = win_r;
    assign tap      = tap_r;
    assign pix_addr = win_origin(win_r) + tap_offset(tap_r);
    assign last_tap = (tap_r == 4'd8);

endmodule

// File: rtl/conv_mac_sequencer.sv
// 4x4 image / 3x3 kernel convolution: sequential 9-tap MAC per window,
// streaming the 2x2 result over a valid/ready handshake.
module conv_mac_sequencer
    import conv_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             pix_we,
    input  logic [3:0]       pix_addr,
    input  logic [PIX_W-1:0] pix_wdata,
    input  logic             ker_we,
    input  logic [3:0]       ker_addr,
    input  logic [PIX_W-1:0] ker_wdata,
    input  logic             start,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [1:0]       out_idx,
    output logic             done
);

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [PIX_W-1:0]   img_r [N_PIX];
    logic [PIX_W-1:0]   ker_r [N_TAP];

    logic [1:0]         win_s;
    logic [3:0]         tap_s;
    logic [3:0]         rd_addr_s;
    logic               last_tap_s;
    logic               clear_s;
    logic               advance_s;
    logic               next_win_s;
    logic [2*PIX_W-1:0] prod_s;
    logic [ACC_W-1:0]   acc_next_s;

    conv_tap_counter u_tap_counter (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (clear_s),
        .advance  (advance_s),
        .next_win (next_win_s),
        .win      (win_s),
        .tap      (tap_s),
        .pix_addr (rd_addr_s),
        .last_tap (last_tap_s)
    );

    assign prod_s     = {{PIX_W{1'b0}}, img_r[rd_addr_s]} * {{PIX_W{1'b0}}, ker_r[tap_s]};
    assign acc_next_s = acc_r + {{(ACC_W-2*PIX_W){1'b0}}, prod_s};

    // Counter control decoded from the current state.
    always_comb begin
        clear_s    = 1'b0;
        advance_s  = 1'b0;
        next_win_s = 1'b0;
        case (state_r)
            ST_IDLE: clear_s    = start;
            ST_ACC:  advance_s  = !last_tap_s;
            ST_OUT:  next_win_s = out_valid && out_ready && (win_s != 2'd3);
            default: begin
                clear_s    = 1'b0;
                advance_s  = 1'b0;
                next_win_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with storage writes, accumulator and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r   <= ST_IDLE;
            acc_r     <= {ACC_W{1'b0}};
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= {ACC_W{1'b0}};
            out_idx   <= 2'd0;
            done      <= 1'b0;
            for (int i = 0; i < N_PIX; i++) img_r[i] <= {PIX_W{1'b0}};
            for (int i = 0; i < N_TAP; i++) ker_r[i] <= {PIX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (pix_we) img_r[pix_addr] <= pix_wdata;
                    if (ker_we && (ker_addr <= 4'd8)) ker_r[ker_addr] <= ker_wdata;
                    if (start) begin
                        state_r <= ST_ACC;
                        acc_r   <= {ACC_W{1'b0}};
                        busy    <= 1'b1;
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_next_s;
                    if (last_tap_s) begin
                        state_r   <= ST_OUT;
                        out_valid <= 1'b1;
                        out_data  <= acc_next_s;
                        out_idx   <= win_s;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (win_s != 2'd3) begin
                            state_r <= ST_ACC;
                            acc_r   <= {ACC_W{1'b0}};
                        end else begin
                            state_r <= ST_FIN;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Self-checking bench for conv_mac_sequencer: directed scenarios plus
// randomized data/ready against a plain-arithmetic convolution model.
module tb_conv_mac_sequencer;

    logic        clk;
    logic        rst_n;
    logic        pix_we;
    logic [3:0]  pix_addr;
    logic [3:0]  pix_wdata;
    logic        ker_we;
    logic [3:0]  ker_addr;
    logic [3:0]  ker_wdata;
    logic        start;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic [1:0]  out_idx;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_img [16];
    int mdl_ker [9];
    int exp_res [4];

    conv_mac_sequencer dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .pix_we    (pix_we),
        .pix_addr  (pix_addr),
        .pix_wdata (pix_wdata),
        .ker_we    (ker_we),
        .ker_addr  (ker_addr),
        .ker_wdata (ker_wdata),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // 2x2 valid convolution straight from the definition.
    task automatic compute_model();
        for (int w = 0; w < 4; w++) begin
            int r0, c0, s;
            r0 = w / 2;
            c0 = w % 2;
            s  = 0;
            for (int kr = 0; kr < 3; kr++)
                for (int kc = 0; kc < 3; kc++)
                    s += mdl_img[(r0 + kr) * 4 + c0 + kc] * mdl_ker[kr * 3 + kc];
            exp_res[w] = s;
        end
    endtask

    // Pixel and kernel written in the same cycle; kernel addresses 9..15 get junk.
    task automatic load_dut();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pix_we    = 1'b1;
            pix_addr  = 4'(i);
            pix_wdata = 4'(mdl_img[i]);
            ker_we    = 1'b1;
            ker_addr  = 4'(i);
            ker_wdata = (i < 9) ? 4'(mdl_ker[i]) : 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        pix_we = 1'b0;
        ker_we = 1'b0;
    endtask

    task automatic set_ramp_center();
        for (int i = 0; i < 16; i++) mdl_img[i] = i;
        for (int i = 0; i < 9; i++) mdl_ker[i] = (i == 4) ? 1 : 0;
    endtask

    // mode 0: ready always high, exact cycle timing checked
    // mode 1: ready low for stall_len cycles while window stall_win is offered
    // mode 2: random ready
    task automatic run_check(input int mode, input int stall_win, input int stall_len,
                             input int inj_c, input bit sw_en,
                             input int sw_addr, input int sw_data);
        int c, nr, stalled;
        bit seen_done;
        if (sw_en) mdl_img[sw_addr] = sw_data;
        compute_model();
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        if (sw_en) begin
            pix_we    = 1'b1;
            pix_addr  = 4'(sw_addr);
            pix_wdata = 4'(sw_data);
        end
        @(negedge clk);
        start  = 1'b0;
        pix_we = 1'b0;
        c = 0; nr = 0; stalled = 0; seen_done = 1'b0;
        while (!seen_done && c < 2000) begin
            if (mode == 0) begin
                check_value("valid_timing", out_valid, (c == 9 || c == 19 || c == 29 || c == 39));
                check_value("done_timing", done, (c == 40));
                check_value("busy_timing", busy, (c < 40));
            end
            if (out_valid) begin
                check_value("out_idx", out_idx, nr);
                check_value("out_data", out_data, (nr < 4) ? exp_res[nr] : -1);
                if (mode == 1 && nr == stall_win && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else if (mode == 2) begin
                    out_ready = 1'($urandom_range(0, 1));
                end else begin
                    out_ready = 1'b1;
                end
                if (out_ready) nr++;
            end else begin
                out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done) begin
                seen_done = 1'b1;
                check_value("results_before_done", nr, 4);
            end
            pix_we    = (c == inj_c);
            start     = (c == inj_c);
            pix_addr  = 4'd5;
            pix_wdata = 4'd15;
            @(negedge clk);
            c++;
        end
        pix_we = 1'b0;
        start  = 1'b0;
        check_value("done_seen", seen_done, 1);
        check_value("done_one_cycle", done, 0);
        check_value("idle_busy", busy, 0);
        check_value("idle_valid", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; pix_we = 1'b0; pix_addr = 4'd0; pix_wdata = 4'd0;
        ker_we = 1'b0; ker_addr = 4'd0; ker_wdata = 4'd0;
        start = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_busy", busy, 0);
        check_value("rst_valid", out_valid, 0);
        check_value("rst_done", done, 0);
        check_value("rst_data", out_data, 0);
        check_value("rst_idx", out_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) mdl_img[i] = 1;
        for (int i = 0; i < 9; i++) mdl_ker[i] = 1;
        load_dut();
        run_check(0, 0, 0, -1, 1'b0, 0, 0);

        set_ramp_center();
        load_dut();
        run_check(0, 0, 0, -1, 1'b0, 0, 0);

        for (int i = 0; i < 16; i++) mdl_img[i] = 15;
        for (int i = 0; i < 9; i++) mdl_ker[i] = 15;
        load_dut();
        run_check(0, 0, 0, -1, 1'b0, 0, 0);

        set_ramp_center();
        load_dut();
        run_check(1, 1, 5, -1, 1'b0, 0, 0);

        // Reset in the middle of window 2 accumulation, then rerun on cleared arrays.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (23) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_value("midrst_busy", busy, 0);
        check_value("midrst_valid", out_valid, 0);
        check_value("midrst_done", done, 0);
        check_value("midrst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mdl_img[i] = 0;
        for (int i = 0; i < 9; i++) mdl_ker[i] = 0;
        run_check(0, 0, 0, -1, 1'b0, 0, 0);

        // Write plus second start while busy must be ignored now and afterwards.
        set_ramp_center();
        load_dut();
        run_check(0, 0, 0, 12, 1'b0, 0, 0);
        run_check(0, 0, 0, -1, 1'b0, 0, 0);

        // Write in the same cycle as start is used by that run.
        run_check(0, 0, 0, -1, 1'b1, 6, 3);

        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 16; i++) mdl_img[i] = $urandom_range(0, 15);
            for (int i = 0; i < 9; i++) mdl_ker[i] = $urandom_range(0, 15);
            load_dut();
            run_check(2, 0, 0, -1, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 15), $urandom_range(0, 15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_mac_sequencer.md
Name: conv_mac_sequencer

Overview:
- Downstream compute stage of the convolution datapath.
- Holds a 4x4 image of 4-bit unsigned pixels and a 3x3 kernel of 4-bit unsigned weights.
- On start, sequentially multiply-accumulates the 9 taps of each of the 4 valid window positions and streams the 2x2 result out over a valid/ready handshake.

Parameters:
PIX_W, 4, pixel and weight width (unsigned)
IMG_DIM, 4, image side length
K_DIM, 3, kernel side length
ACC_W, 11, accumulator/result width (9*15*15 = 2025 fits exactly)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  reset, asynchronous, active-low; clears all state and both storage arrays
pix_we  in  1  pixel write strobe
pix_addr  in  4  pixel index, row*4+col
pix_wdata  in  PIX_W  pixel value
ker_we  in  1  kernel write strobe
ker_addr  in  4  kernel index, row*3+col; values 9..15 are ignored
ker_wdata  in  PIX_W  weight value
start  in  1  begin convolution; sampled in IDLE only
busy  out  1  high in ACC and OUT
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
out_data  out  ACC_W  convolution result
out_idx  out  2  window index: 0=(0,0), 1=(0,1), 2=(1,0), 3=(1,1) (top-left row,col)
done  out  1  one-cycle pulse after the last result transfers

Behaviour:
- Reset (RESET low, any time including mid-operation):
  - State returns to IDLE; window, tap and accumulator are cleared.
  - Image and kernel arrays are all 0.
  - busy, out_valid, done, out_data and out_idx are all 0.
- States: IDLE, ACC, OUT, FIN.
- IDLE:
  - Writes are accepted: pix_we writes img[pix_addr]; ker_we with ker_addr<=8 writes ker[ker_addr].
  - Simultaneous pixel and kernel writes are both performed.
  - start=1 -> ACC with win=0, tap=0, acc=0.
  - A write and start in the same cycle: the write takes effect and is visible to the run.
- ACC:
  - Each cycle: acc <= acc + img[(r0+tap/3)*4 + (c0+tap%3)] * ker[tap], then tap increments.
  - The 8-bit product is zero-extended to ACC_W. No overflow is possible.
  - After the tap=8 update -> OUT. Exactly 9 cycles are spent in ACC per window.
- OUT:
  - out_valid=1, out_data=acc, out_idx=win.
  - Values are held stable while out_ready=0. There is no timeout.
  - On out_valid & out_ready: if win<3, go to ACC with win+1, tap=0, acc=0; if win=3, go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k gives first out_valid high after edge k+9. With out_ready held at 1, results arrive at 10-cycle spacing and done is high 40 cycles after start is sampled.
- Ignored inputs: start outside IDLE; pix_we and ker_we outside IDLE (arrays are unchanged).
- out_valid never asserts outside OUT, and out_idx changes only on a completed transfer.

Decomposition:
- Shared package conv_pkg holds:
  - PIX_W, IMG_DIM, K_DIM and ACC_W constants.
  - The state encoding IDLE=2'b00, ACC=2'b01, OUT=2'b10, FIN=2'b11.
  - The window origin table (r0,c0) per index.
- One sub-module: conv_tap_counter.
  - Registered win[1:0] and tap[3:0], with clear and advance controls.
  - Combinational pixel address and last_tap flag.
  - Async active-low reset on the same CLK/RESET.
- The MAC, storage arrays and FSM stay in the top module.

Test Plan:
- All 16 pixels = 1, all 9 weights = 1, out_ready=1, start -> out_data 9,9,9,9 with out_idx 0,1,2,3 at 10-cycle spacing; done pulse once, 40 cycles after start is sampled.
- Pixel[i] = i (0..15), kernel center ker[4]=1 and other weights 0 -> out_data 5,6,9,10.
- All pixels = 15, all weights = 15 -> out_data 2025 for every window; no wrap.
- Same data as the second scenario, out_ready=0 for 5 cycles while out_idx=1 is valid -> out_data held at 6 and out_valid held at 1; after ready rises, the sequence continues with 9,10 and none is dropped or duplicated.
- Pull RESET low during ACC of window 2 -> busy, out_valid and done go to 0 immediately. Re-run start without reloading -> outputs 0,0,0,0.
- Write pix_addr=5 with value 15 and assert a second start while busy -> no effect on the current run. A run after done uses the prior value of pixel 5.
